// File: rtl/ctr_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding and default widths.
package ctr_sched_pkg;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_DATA_W = 5;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COUNT = 3'd2,
        ST_READ  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above i_ptr, wrapping.
module rr_arbiter
    import ctr_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_grant_id,
    output logic            o_any
);

    logic [NREQ-1:0] w_rot;
    logic [ID_W:0]   w_pos;
    logic [ID_W:0]   w_sum;

    // Rotate so bit 0 is the requester at i_ptr; the lowest set bit is then the winner.
    assign w_rot = NREQ'({i_req, i_req} >> i_ptr);
    assign o_any = |i_req;

    always_comb begin
        w_pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_pos = (ID_W + 1)'(k);
            end
        end
    end

    assign w_sum      = {1'b0, i_ptr} + w_pos;
    assign o_grant_id = (w_sum >= (ID_W + 1)'(NREQ)) ? ID_W'(w_sum - (ID_W + 1)'(NREQ))
                                                     : ID_W'(w_sum);

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
            assign o_grant[gi] = o_any && (o_grant_id == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/counter_sched.sv
// Shares one loadable up-counter among NREQ requesters: load, count len cycles,
// read the result back and return it over a valid/ready response.
module counter_sched
    import ctr_sched_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ID_W   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DATA_W-1:0]  req_start,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic                    ctr_load,
    output logic [DATA_W-1:0]       ctr_data,
    output logic                    ctr_count,
    output logic                    ctr_oe,
    input  logic [CNT_W-1:0]        ctr_value,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [CNT_W-1:0]        rsp_value,
    output logic                    busy
);

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_start;
    logic [LEN_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_rsp_value;

    logic [NREQ-1:0]     w_grant;
    logic [ID_W-1:0]     w_gid;
    logic                w_any;
    logic [DATA_W-1:0]   w_start_arr [NREQ];
    logic [LEN_W-1:0]    w_len_arr   [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_start_arr[gi] = req_start[gi*DATA_W +: DATA_W];
            assign w_len_arr[gi]   = req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req      (req_valid),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_gid),
        .o_any      (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        ctr_load     = 1'b0;
        ctr_data     = '0;
        ctr_count    = 1'b0;
        ctr_oe       = 1'b0;
        rsp_valid    = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                // Gated by rst_n so every output reads 0 while reset is held.
                req_ready = rst_n ? w_grant : '0;
                if (w_any) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                ctr_load     = 1'b1;
                ctr_data     = r_start;
                w_state_next = (r_remaining == '0) ? ST_READ : ST_COUNT;
            end
            ST_COUNT: begin
                ctr_count = 1'b1;
                if (r_remaining == LEN_W'(1)) w_state_next = ST_READ;
            end
            ST_READ: begin
                ctr_oe       = 1'b1;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_start     <= '0;
            r_remaining <= '0;
            r_rsp_value <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_start     <= w_start_arr[w_gid];
                        r_remaining <= w_len_arr[w_gid];
                        r_id        <= w_gid;
                    end
                end
                ST_COUNT: r_remaining <= r_remaining - LEN_W'(1);
                ST_READ:  r_rsp_value <= ctr_value;
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rr_ptr <= (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_id    = r_id;
    assign rsp_value = r_rsp_value;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: a counter datapath model, a timeline scoreboard checked
// every cycle, and directed transactions with hand-computed results.
module tb_counter_sched;

    localparam int NREQ   = 2;
    localparam int DATA_W = 5;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 8;
    localparam int ID_W   = 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_start = '0;
    logic [NREQ*LEN_W-1:0]  req_len = '0;
    logic                   ctr_load;
    logic [DATA_W-1:0]      ctr_data;
    logic                   ctr_count;
    logic                   ctr_oe;
    logic [CNT_W-1:0]       ctr_value;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b1;
    logic [ID_W-1:0]        rsp_id;
    logic [CNT_W-1:0]       rsp_value;
    logic                   busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    counter_sched #(
        .NREQ (NREQ), .DATA_W (DATA_W), .LEN_W (LEN_W), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_start (req_start), .req_len (req_len),
        .ctr_load (ctr_load), .ctr_data (ctr_data),
        .ctr_count (ctr_count), .ctr_oe (ctr_oe), .ctr_value (ctr_value),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
        .rsp_id (rsp_id), .rsp_value (rsp_value), .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External 8-bit counter datapath.
    logic [CNT_W-1:0] cnt = '0;
    always @(posedge clk) begin
        if (ctr_load)       cnt <= CNT_W'(ctr_data);
        else if (ctr_count) cnt <= cnt + 8'd1;
    end
    assign ctr_value = ctr_oe ? cnt : '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: a job accepted at cycle t loads at t+1, counts t+2..t+len+1,
    // reads at t+len+2 and responds from t+len+3 with (start+len) mod 256.
    bit m_active = 1'b0;
    int m_t, m_len, m_id, m_val, m_start;
    int m_ptr = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_ready;
        int d;
        int g;
        e_ready = '0;
        g = -1;
        if (!rst_n) begin
            m_active = 1'b0;
            m_ptr    = 0;
            chk("reset_outputs", {req_ready, ctr_load, ctr_count, ctr_oe, rsp_valid, busy,
                                  rsp_id, rsp_value, ctr_data}, 0);
        end else if (!m_active) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
            if (g >= 0) e_ready[g] = 1'b1;
            chk("idle_req_ready", req_ready, e_ready);
            chk("idle_ctrl", {ctr_load, ctr_count, ctr_oe, rsp_valid, busy}, 0);
            if (g >= 0) begin
                m_active = 1'b1;
                m_t      = cyc;
                m_id     = g;
                m_start  = int'(req_start[g*DATA_W +: DATA_W]);
                m_len    = int'(req_len[g*LEN_W +: LEN_W]);
                m_val    = (m_start + m_len) % 256;
            end
        end else begin
            d = cyc - m_t;
            chk("busy_req_ready", req_ready, 0);
            chk("busy", busy, 1);
            chk("ctr_load", ctr_load, d == 1);
            chk("ctr_count", ctr_count, (d >= 2) && (d <= m_len + 1));
            chk("ctr_oe", ctr_oe, d == m_len + 2);
            chk("rsp_valid", rsp_valid, d >= m_len + 3);
            if (d == 1) chk("ctr_data", ctr_data, m_start);
            if (d >= m_len + 3) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_value", rsp_value, m_val);
                if (rsp_ready) begin
                    m_active = 1'b0;
                    m_ptr    = (m_id + 1) % NREQ;
                end
            end
        end
    end

    // One request from a single requester; checks grant, latency, pulse counts and result.
    task automatic do_req(input int id, input int start, input int len,
                          input int exp_val, input int exp_lat, input string nm);
        int n, t0, nc, nl;
        @(posedge clk); #1;
        req_start[id*DATA_W +: DATA_W] = DATA_W'(start);
        req_len[id*LEN_W +: LEN_W]     = LEN_W'(len);
        req_valid[id] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[id] && n < 50);
        chk({nm, "_grant_timeout"}, n < 50, 1);
        t0 = cyc;
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        n = 0; nc = 0; nl = 0;
        do begin
            @(negedge clk);
            n++;
            if (ctr_count) nc++;
            if (ctr_load) nl++;
        end while (!rsp_valid && n < 400);
        chk({nm, "_rsp_timeout"}, n < 400, 1);
        chk({nm, "_latency"}, cyc - t0, exp_lat);
        chk({nm, "_loads"}, nl, 1);
        chk({nm, "_counts"}, nc, len);
        chk({nm, "_id"}, rsp_id, id);
        chk({nm, "_value"}, rsp_value, exp_val);
        $display("txn %s: req%0d start=%0d len=%0d -> id=%0d value=%0d latency=%0d",
                 nm, id, start, len, rsp_id, rsp_value, cyc - t0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ctr_oe", ctr_oe, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_req_ready", req_ready, 0);

        do_req(0, 3, 5, 8, 8, "single");
        do_req(1, 17, 0, 17, 3, "len0");
        do_req(0, 31, 255, 30, 258, "wrap");

        // Contention from reset: both requesters held valid.
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_start = {5'd4, 5'd2};
        req_len   = {8'd2, 8'd1};
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
            chk("contend_timeout", n < 50, 1);
            chk("contend_id", rsp_id, i % 2);
            chk("contend_value", rsp_value, (i % 2) ? 6 : 3);
            $display("txn contend[%0d]: id=%0d value=%0d", i, rsp_id, rsp_value);
            @(posedge clk); #1;
            if (i == 3) req_valid = '0;
        end

        // Backpressure: req0 wins (ptr=0); req1 waits while the response is held.
        rsp_ready = 1'b0;
        req_start = {5'd9, 5'd1};
        req_len   = {8'd1, 8'd0};
        req_valid = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        chk("bp_timeout", n < 50, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 0);
            chk("bp_value", rsp_value, 1);
            chk("bp_req_ready", req_ready, 0);
        end
        $display("txn backpressure: id=%0d value=%0d held 10 cycles", rsp_id, rsp_value);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;

        // Async reset during COUNT (ptr is now 1); afterwards req0 must win from ptr=0.
        req_start[4:0] = 5'd0;
        req_len[7:0]   = 8'd20;
        req_valid = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (!ctr_count && n < 50);
        chk("arst_count_timeout", n < 50, 1);
        repeat (3) @(posedge clk);
        req_valid = 2'b11;
        req_start = {5'd6, 5'd5};
        req_len   = {8'd1, 8'd2};
        #3 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {req_ready, ctr_load, ctr_count, ctr_oe, rsp_valid, busy}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        chk("arst_fresh_timeout", n < 50, 1);
        chk("arst_fresh_id", rsp_id, 0);
        chk("arst_fresh_value", rsp_value, 7);
        $display("txn after_reset: id=%0d value=%0d", rsp_id, rsp_value);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
